fmv_frame_queue: RTL and testbench

Frame buffer manager between the FMV MPEG picture decoder and the display-side frame player. It owns a pool of planar YUV frame buffers in DDR, hands free buffers to the decoder, and queues completed pictures in display order. On each display tick it selects the frame to show and emits the `planar_yuv_s` descriptor plus latch and invalidate pulses that the player consumes. Single clock domain, `clkddr`; the display tick arrives already synchronized.

---
 rtl/fmv_frame_queue.sv | 182 ++++++++++++++++++
 tb/tb_fmv_frame_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmv_frame_queue.sv
// rtl/fmv_frame_queue.sv - FMV frame buffer pool and display-order queue; FMV_QUEUE_CATCHUP_EN enables stale-frame dropping
package fmv_frame_queue_pkg;
  typedef struct packed {
    logic [28:0] y_adr;
    logic [28:0] u_adr;
    logic [28:0] v_adr;
    logic [8:0]  width;
    logic [8:0]  height;
  } planar_yuv_s;
endpackage

module fmv_frame_queue
  import fmv_frame_queue_pkg::*;
#(
  parameter int          NUM_BUFFERS   = 4,
  parameter logic [28:0] BASE_ADR      = 29'h0,
  parameter logic [28:0] BUFFER_STRIDE = 29'h40000
) (
  input  logic        clkddr,
  input  logic        reset,
  input  logic [8:0]  frame_width,
  input  logic [8:0]  frame_height,
  input  logic        alloc_req,
  output logic        alloc_ack,
  output planar_yuv_s alloc_frame,
  input  logic        commit,
  input  logic        discard,
  input  logic        display_tick,
  input  logic [2:0]  repeat_count,
  input  logic        flush,
  output planar_yuv_s frame,
  output logic        latch_frame,
  output logic        invalidate,
  output logic [3:0]  queue_level
);
  localparam int IW    = $clog2(NUM_BUFFERS);
  localparam int SLOTS = 1 << IW;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_DECODING, SLOT_QUEUED, SLOT_SHOWN} slot_e;
  typedef enum logic [1:0] {ALLOC_IDLE, ALLOC_SEARCH, ALLOC_OWNED} alloc_e;

  slot_e         slot_q [SLOTS];
  slot_e         slot_d [SLOTS];
  logic [IW-1:0] fifo_mem [SLOTS];
  logic [IW-1:0] rd_ptr, wr_ptr, rd_base, wr_base;
  logic [3:0]    count, cnt_base;
  alloc_e        alloc_state, alloc_next;
  logic [IW-1:0] owned_idx, free_idx, shown_idx, head_idx, show_idx;
  logic          free_found, shown_valid;
  logic          grant, do_commit, do_discard, do_latch, do_skip;
  logic [2:0]    tick_cnt, rc_eff;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NUM_BUFFERS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic planar_yuv_s make_desc(input logic [IW-1:0] idx);
    logic [17:0] area;
    planar_yuv_s d;
    area     = {9'b0, frame_width} * {9'b0, frame_height};
    d.y_adr  = BASE_ADR + BUFFER_STRIDE * 29'(idx);
    d.u_adr  = d.y_adr + {11'b0, area};
    d.v_adr  = d.u_adr + {13'b0, area[17:2]};
    d.width  = frame_width;
    d.height = frame_height;
    return d;
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (slot_q[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    alloc_next = alloc_state;
    grant      = 1'b0;
    do_commit  = 1'b0;
    do_discard = 1'b0;
    case (alloc_state)
      ALLOC_IDLE:   if (alloc_req) alloc_next = ALLOC_SEARCH;
      ALLOC_SEARCH: if (free_found) begin
        grant      = 1'b1;
        alloc_next = ALLOC_OWNED;
      end
      ALLOC_OWNED: begin
        do_discard = discard;
        do_commit  = commit && !discard;
        if (commit || discard) alloc_next = ALLOC_IDLE;
      end
      default: alloc_next = ALLOC_IDLE;
    endcase
  end

  // A tick only latches when the repeat countdown has expired; flush suppresses the tick entirely.
  always_comb begin
    rc_eff   = (repeat_count == 3'd0) ? 3'd1 : repeat_count;
    do_latch = display_tick && !flush && (tick_cnt <= 3'd1) && (count != 4'd0);
`ifdef FMV_QUEUE_CATCHUP_EN
    do_skip  = do_latch && (count >= 4'(NUM_BUFFERS - 1));
`else
    do_skip  = 1'b0;
`endif
    head_idx = fifo_mem[rd_ptr];
    show_idx = do_skip ? fifo_mem[ptr_inc(rd_ptr)] : head_idx;
    rd_base  = flush ? '0 : (do_skip ? ptr_inc(ptr_inc(rd_ptr)) : (do_latch ? ptr_inc(rd_ptr) : rd_ptr));
    wr_base  = flush ? '0 : wr_ptr;
    cnt_base = flush ? '0 : count - (do_skip ? 4'd2 : {3'b0, do_latch});
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) slot_d[i] = slot_q[i];
    if (flush) begin
      for (int i = 0; i < NUM_BUFFERS; i++)
        if (slot_q[i] == SLOT_QUEUED || slot_q[i] == SLOT_SHOWN) slot_d[i] = SLOT_FREE;
    end else if (do_latch) begin
      if (shown_valid) slot_d[shown_idx] = SLOT_FREE;
      if (do_skip)     slot_d[head_idx]  = SLOT_FREE;
      slot_d[show_idx] = SLOT_SHOWN;
    end
    if (grant)      slot_d[free_idx]  = SLOT_DECODING;
    if (do_commit)  slot_d[owned_idx] = SLOT_QUEUED;
    if (do_discard) slot_d[owned_idx] = SLOT_FREE;
  end

  always_ff @(posedge clkddr or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i]   <= SLOT_FREE;
        fifo_mem[i] <= '0;
      end
      alloc_state <= ALLOC_IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      owned_idx   <= '0;
      shown_idx   <= '0;
      shown_valid <= 1'b0;
      tick_cnt    <= '0;
      alloc_ack   <= 1'b0;
      alloc_frame <= '0;
      frame       <= '0;
      latch_frame <= 1'b0;
      invalidate  <= 1'b1;
    end else begin
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= slot_d[i];
      alloc_state <= alloc_next;
      alloc_ack   <= grant;
      if (grant) begin
        alloc_frame <= make_desc(free_idx);
        owned_idx   <= free_idx;
      end
      if (do_commit) fifo_mem[wr_base] <= owned_idx;
      wr_ptr      <= do_commit ? ptr_inc(wr_base) : wr_base;
      rd_ptr      <= rd_base;
      count       <= cnt_base + {3'b0, do_commit};
      latch_frame <= do_latch;
      invalidate  <= flush;
      if (flush) begin
        shown_valid <= 1'b0;
      end else if (display_tick) begin
        if (do_latch) begin
          frame       <= make_desc(show_idx);
          shown_idx   <= show_idx;
          shown_valid <= 1'b1;
          tick_cnt    <= rc_eff;
        end else if (tick_cnt <= 3'd1) begin
          tick_cnt <= 3'd0;
        end else begin
          tick_cnt <= tick_cnt - 3'd1;
        end
      end
    end
  end

  assign queue_level = count;
endmodule

// File: tb/tb_fmv_frame_queue.sv
// tb/tb_fmv_frame_queue.sv - scoreboard bench for fmv_frame_queue at 352x240, four buffers
module tb_fmv_frame_queue;
  import fmv_frame_queue_pkg::*;

`ifdef FMV_QUEUE_CATCHUP_EN
  localparam bit CATCHUP = 1'b1;
`else
  localparam bit CATCHUP = 1'b0;
`endif

  logic        clkddr, reset;
  logic [8:0]  frame_width, frame_height;
  logic        alloc_req, alloc_ack, commit, discard, display_tick, flush;
  logic        latch_frame, invalidate;
  logic [2:0]  repeat_count;
  logic [3:0]  queue_level;
  planar_yuv_s alloc_frame, frame;

  int checks = 0;
  int errors = 0;
  logic [86:0] exp_alloc_q[$];
  logic [86:0] exp_latch_q[$];
  int exp_inv = 0;

  fmv_frame_queue #(.NUM_BUFFERS(4), .BASE_ADR(29'h0), .BUFFER_STRIDE(29'h40000)) dut (
    .clkddr(clkddr), .reset(reset), .frame_width(frame_width), .frame_height(frame_height),
    .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_frame(alloc_frame),
    .commit(commit), .discard(discard), .display_tick(display_tick),
    .repeat_count(repeat_count), .flush(flush), .frame(frame),
    .latch_frame(latch_frame), .invalidate(invalidate), .queue_level(queue_level)
  );

  initial clkddr = 1'b0;
  always #5 clkddr = ~clkddr;

  // 352x240: w*h = 0x14A00, quarter = 0x5280
  function automatic logic [86:0] desc(input int s);
    case (s)
      0:       desc = {29'h00000, 29'h14A00, 29'h19C80};
      1:       desc = {29'h40000, 29'h54A00, 29'h59C80};
      2:       desc = {29'h80000, 29'h94A00, 29'h99C80};
      default: desc = {29'hC0000, 29'hD4A00, 29'hD9C80};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clkddr) begin
    if (!reset) begin
      if (alloc_ack) begin
        checks++;
        if (exp_alloc_q.size() == 0) begin
          errors++;
          $display("FAIL alloc_unexpected: got y=%0h expected no grant", alloc_frame.y_adr);
        end else begin
          logic [86:0] e;
          e = exp_alloc_q.pop_front();
          if ({alloc_frame.y_adr, alloc_frame.u_adr, alloc_frame.v_adr} !== e) begin
            errors++;
            $display("FAIL alloc_desc: got %h expected %h",
                     {alloc_frame.y_adr, alloc_frame.u_adr, alloc_frame.v_adr}, e);
          end
        end
      end
      if (latch_frame) begin
        checks++;
        if (exp_latch_q.size() == 0) begin
          errors++;
          $display("FAIL latch_unexpected: got y=%0h expected no latch", frame.y_adr);
        end else begin
          logic [86:0] e;
          e = exp_latch_q.pop_front();
          if ({frame.y_adr, frame.u_adr, frame.v_adr} !== e) begin
            errors++;
            $display("FAIL latch_desc: got %h expected %h", {frame.y_adr, frame.u_adr, frame.v_adr}, e);
          end
        end
      end
      if (invalidate) begin
        checks++;
        if (exp_inv == 0) begin
          errors++;
          $display("FAIL invalidate_unexpected: got 1 expected 0");
        end else begin
          exp_inv--;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkddr);
    #1;
  endtask

  task automatic do_alloc(input int slot);
    int lat;
    bit got;
    exp_alloc_q.push_back(desc(slot));
    alloc_req = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      step(1);
      if (alloc_ack) begin
        got = 1'b1;
        lat = c;
      end
    end
    alloc_req = 1'b0;
    check("alloc_latency", lat, 2);
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step(1);
    commit = 1'b0;
  endtask

  task automatic tick();
    display_tick = 1'b1;
    step(1);
    display_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_width = 9'd352; frame_height = 9'd240;
    alloc_req = 0; commit = 0; discard = 0; display_tick = 0; flush = 0;
    repeat_count = 3'd2;
    exp_inv = 1;
    step(3);
    reset = 1'b0;
    check("rst_alloc_ack", 32'(alloc_ack), 0);
    check("rst_latch", 32'(latch_frame), 0);
    check("rst_invalidate", 32'(invalidate), 1);
    check("rst_level", 32'(queue_level), 0);
    check("rst_frame_y", 32'(frame.y_adr), 0);
    check("rst_alloc_frame_v", 32'(alloc_frame.v_adr), 0);
    step(1);
    check("rst_invalidate_drop", 32'(invalidate), 0);

    do_alloc(0); pulse_commit();
    do_alloc(1); pulse_commit();
    check("level_two", 32'(queue_level), 2);

    exp_latch_q.push_back(desc(0));
    exp_latch_q.push_back(desc(1));
    tick(); check("tick1_latch", 32'(latch_frame), 1); check("tick1_level", 32'(queue_level), 1);
    step(2);
    tick(); check("tick2_latch", 32'(latch_frame), 0);
    step(2);
    tick(); check("tick3_latch", 32'(latch_frame), 1); check("tick3_level", 32'(queue_level), 0);
    step(2);
    tick(); check("tick4_latch", 32'(latch_frame), 0);

    do_alloc(0);
    discard = 1'b1; step(1); discard = 1'b0;
    check("discard_level", 32'(queue_level), 0);
    do_alloc(0); pulse_commit();
    do_alloc(2); pulse_commit();
    do_alloc(3); pulse_commit();
    check("full_level", 32'(queue_level), 3);

    exp_alloc_q.push_back(desc(CATCHUP ? 0 : 1));
    exp_latch_q.push_back(desc(CATCHUP ? 2 : 0));
    alloc_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("stall_no_ack", 32'(alloc_ack), 0);
    end
    tick();
    check("stall_latch", 32'(latch_frame), 1);
    check("stall_ack_not_yet", 32'(alloc_ack), 0);
    step(1);
    check("stall_ack", 32'(alloc_ack), 1);
    alloc_req = 1'b0;
    check("stall_level", 32'(queue_level), CATCHUP ? 1 : 2);

    exp_inv++;
    flush = 1'b1; display_tick = 1'b1;
    step(1);
    flush = 1'b0; display_tick = 1'b0;
    check("flush_invalidate", 32'(invalidate), 1);
    check("flush_no_latch", 32'(latch_frame), 0);
    check("flush_level", 32'(queue_level), 0);
    step(1);
    check("flush_invalidate_drop", 32'(invalidate), 0);
    pulse_commit();
    check("retained_commit_level", 32'(queue_level), 1);
    repeat_count = 3'd0;
    exp_latch_q.push_back(desc(CATCHUP ? 0 : 1));
    tick(); step(2);
    tick(); step(2);
    check("retained_level", 32'(queue_level), 0);

    do_alloc(CATCHUP ? 1 : 0); pulse_commit();
    do_alloc(2); pulse_commit();
    do_alloc(3); pulse_commit();
    check("three_level", 32'(queue_level), 3);
    exp_latch_q.push_back(desc(CATCHUP ? 2 : (CATCHUP ? 1 : 0)));
    tick();
    check("three_latch", 32'(latch_frame), 1);
    check("three_after_level", 32'(queue_level), CATCHUP ? 1 : 2);

    step(3);
    check("alloc_sb_empty", exp_alloc_q.size(), 0);
    check("latch_sb_empty", exp_latch_q.size(), 0);
    check("inv_sb_empty", exp_inv, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
